// File: rtl/cpu_timing_fsm_pkg.sv
// ---------------------------------------------------------------------------
// cpu_timing_fsm_pkg
// Shared CPU definitions: instruction-cycle state encodings used by the
// timing sequencer and by control_logic, plus the EX-phase sizing helper.
// ---------------------------------------------------------------------------
package cpu_timing_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_IF1  = 3'd1,
    ST_IF2  = 3'd2,
    ST_EX1  = 3'd3,
    ST_EX2  = 3'd4,
    ST_EX3  = 3'd5,
    ST_EX4  = 3'd6
  } cpu_state_e;

  // Number of EX beats for the decoded instruction. LW outranks SW when the
  // decoder asserts both. The value 4 (EX4) is reserved and never produced.
  function automatic logic [2:0] beats_for(input logic sw, input logic lw);
    if (lw)      return 3'd3;
    else if (sw) return 3'd2;
    else         return 3'd1;
  endfunction

endpackage

// File: rtl/cpu_wait_timer.sv
// ---------------------------------------------------------------------------
// cpu_wait_timer
// Counts cycles spent waiting on a bus beat and flags the last allowed cycle.
// Ports:
//   clk       in  clock, rising edge
//   rst_n     in  synchronous reset, active-low
//   clr_i     in  clear counter to 0 (takes priority over en_i)
//   en_i      in  count one waiting cycle
//   expire_o  out counter has reached TIMEOUT-1 (registered-count decode)
// ---------------------------------------------------------------------------
module cpu_wait_timer #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = $clog2(TIMEOUT);
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_o) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/cpu_timing_fsm.sv
// ---------------------------------------------------------------------------
// cpu_timing_fsm
// Instruction-cycle sequencer: IDLE -> IF1 -> IF2 -> EX1..EXn -> IF1.
// Advances on output_done from control_logic, sizes EX from the decode flags
// latched in IF2, counts retired instructions and aborts hung bus waits.
// Ports:
//   clk, rst_n            clock / synchronous active-low reset
//   run                   1 = keep fetching, 0 = stop at instruction boundary
//   output_done           beat complete from control_logic
//   ins_SW, ins_LW        decode flags, sampled in IF2
//   cur_state             current state code
//   Mif, Mex              fetch / execute phase flags
//   T1_Mif, T2_Mif        first-cycle strobes of IF1 / IF2
//   T1..T4                first-cycle strobes of EX1..EX4
//   ins_retired           one-cycle pulse after the last EX beat completes
//   instr_count           retired-instruction counter (wraps)
//   timeout_err           sticky bus-wait timeout flag
//   busy                  state is not IDLE
// All outputs come from registers; none depends combinationally on output_done.
// ---------------------------------------------------------------------------
module cpu_timing_fsm
  import cpu_timing_fsm_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             output_done,
  input  logic             ins_SW,
  input  logic             ins_LW,
  output logic [2:0]       cur_state,
  output logic             Mif,
  output logic             Mex,
  output logic             T1_Mif,
  output logic             T2_Mif,
  output logic             T1,
  output logic             T2,
  output logic             T3,
  output logic             T4,
  output logic             ins_retired,
  output logic [CNT_W-1:0] instr_count,
  output logic             timeout_err,
  output logic             busy
);

  cpu_state_e       state_q, state_d;
  logic             entry_q;
  logic [2:0]       beats_q, beats_d;
  logic             retired_q, retire_d;
  logic [CNT_W-1:0] count_q;
  logic             err_q, err_d;
  logic             wait_en, wait_clr, wait_exp;
  logic [2:0]       ex_idx;
  logic [2:0]       st_inc;
  logic             ex2_bus;

  cpu_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (wait_clr),
    .en_i     (wait_en),
    .expire_o (wait_exp)
  );

  always_comb begin
    state_d  = state_q;
    beats_d  = beats_q;
    retire_d = 1'b0;
    err_d    = err_q;
    wait_en  = 1'b0;
    ex_idx   = 3'(state_q) - 3'd2;   // EX1 -> 1, EX2 -> 2, ...
    st_inc   = 3'(state_q) + 3'd1;
    ex2_bus  = (state_q == ST_EX2) && (beats_q >= 3'd2);

    case (state_q)
      ST_IDLE: begin
        if (run && !err_q) state_d = ST_IF1;
      end
      ST_IF1: begin
        wait_en = !output_done;
        if (output_done) begin
          state_d = ST_IF2;
        end else if (wait_exp) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      ST_IF2: begin
        // Single cycle; output_done is deliberately ignored here.
        beats_d = beats_for(ins_SW, ins_LW);
        state_d = ST_EX1;
      end
      ST_EX1, ST_EX2, ST_EX3, ST_EX4: begin
        if (ex2_bus) wait_en = !output_done;
        if (output_done) begin
          if (ex_idx < beats_q) begin
            state_d = cpu_state_e'(st_inc);
          end else begin
            // Last beat: run is only consulted here and in IDLE.
            retire_d = 1'b1;
            state_d  = run ? ST_IF1 : ST_IDLE;
          end
        end else if (ex2_bus && wait_exp) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Every state change restarts the wait count.
    wait_clr = (state_d != state_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      entry_q   <= 1'b0;
      beats_q   <= 3'd0;
      retired_q <= 1'b0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      entry_q   <= (state_d != state_q);
      beats_q   <= beats_d;
      retired_q <= retire_d;
      err_q     <= err_d;
      if (retire_d) count_q <= count_q + CNT_W'(1);
    end
  end

  // Strobes are qualified by the registered entry flag so a long dwell
  // produces only one pulse.
  assign cur_state   = state_q;
  assign Mif         = (state_q == ST_IF1) || (state_q == ST_IF2);
  assign Mex         = (state_q == ST_EX1) || (state_q == ST_EX2) ||
                       (state_q == ST_EX3) || (state_q == ST_EX4);
  assign T1_Mif      = entry_q && (state_q == ST_IF1);
  assign T2_Mif      = entry_q && (state_q == ST_IF2);
  assign T1          = entry_q && (state_q == ST_EX1);
  assign T2          = entry_q && (state_q == ST_EX2);
  assign T3          = entry_q && (state_q == ST_EX3);
  assign T4          = entry_q && (state_q == ST_EX4);
  assign ins_retired = retired_q;
  assign instr_count = count_q;
  assign timeout_err = err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_cpu_timing_fsm.sv
module tb_cpu_timing_fsm;

  localparam int S_IDLE = 0, S_IF1 = 1, S_IF2 = 2, S_EX1 = 3, S_EX2 = 4, S_EX3 = 5;
  localparam int K_ADD = 0, K_SW = 1, K_LW = 2, K_BOTH = 3;
  localparam int TMO = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       output_done = 1'b0;
  logic       ins_SW = 1'b0;
  logic       ins_LW = 1'b0;
  logic [2:0] cur_state;
  logic       Mif, Mex, T1_Mif, T2_Mif, T1, T2, T3, T4;
  logic       ins_retired, timeout_err, busy;
  logic [3:0] instr_count;

  cpu_timing_fsm #(
    .TIMEOUT (TMO),
    .CNT_W   (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .output_done (output_done),
    .ins_SW      (ins_SW),
    .ins_LW      (ins_LW),
    .cur_state   (cur_state),
    .Mif         (Mif),
    .Mex         (Mex),
    .T1_Mif      (T1_Mif),
    .T2_Mif      (T2_Mif),
    .T1          (T1),
    .T2          (T2),
    .T3          (T3),
    .T4          (T4),
    .ins_retired (ins_retired),
    .instr_count (instr_count),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] st;
    logic       first;
    logic       ret;
    logic [3:0] cnt;
    logic       err;
  } exp_t;

  exp_t       sbq[$];
  int         n_tot = 0;
  int         n_bad = 0;
  logic [3:0] exp_cnt = 4'd0;
  logic       exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tot++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Monitor: compare the state reached after each edge with what the driver queued.
  always @(posedge clk) begin
    exp_t e;
    logic [5:0] strb;
    #2;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      strb = {e.first && e.st == 3'd1, e.first && e.st == 3'd2, e.first && e.st == 3'd3,
              e.first && e.st == 3'd4, e.first && e.st == 3'd5, e.first && e.st == 3'd6};
      chk("state", 32'(cur_state), 32'(e.st));
      chk("strobes", 32'({T1_Mif, T2_Mif, T1, T2, T3, T4}), 32'(strb));
      chk("retired", 32'(ins_retired), 32'(e.ret));
      chk("count", 32'(instr_count), 32'(e.cnt));
      chk("tmo_err", 32'(timeout_err), 32'(e.err));
      chk("phase", 32'({Mif, Mex, busy}),
          32'({e.st == 3'd1 || e.st == 3'd2, e.st >= 3'd3 && e.st <= 3'd6, e.st != 3'd0}));
    end
  end

  task automatic push(input int st, input logic first, input logic ret);
    exp_t e;
    e.st = 3'(st); e.first = first; e.ret = ret; e.cnt = exp_cnt; e.err = exp_err;
    sbq.push_back(e);
  endtask

  // One cycle of stimulus plus the state expected after the next edge.
  task automatic drv(input logic r, input logic d, input logic s, input logic l,
                     input int nst, input logic first, input logic ret);
    @(negedge clk);
    rst_n = 1'b1; run = r; output_done = d; ins_SW = s; ins_LW = l;
    if (ret) exp_cnt = exp_cnt + 4'd1;
    push(nst, first, ret);
  endtask

  task automatic do_rst();
    @(negedge clk);
    rst_n = 1'b0; run = 1'b1; output_done = 1'b1; ins_SW = 1'b0; ins_LW = 1'b1;
    exp_cnt = 4'd0; exp_err = 1'b0;
    push(S_IDLE, 1'b0, 1'b0);
  endtask

  task automatic start();
    drv(1, 0, 0, 0, S_IF1, 1, 0);
  endtask

  // Entered in the first cycle of IF1. exw=0 means EX2 never completes.
  task automatic run_instr(input int kind, input int ifw, input int exw, input logic run_end);
    int endst;
    logic is_lw;
    endst = run_end ? S_IF1 : S_IDLE;
    is_lw = (kind == K_LW) || (kind == K_BOTH);
    for (int i = 1; i <= ifw; i++)
      drv(1, i == ifw, 0, 0, (i == ifw) ? S_IF2 : S_IF1, i == ifw, 0);
    // IF2 with output_done high: must still take exactly one cycle.
    drv(1, 1, kind == K_SW || kind == K_BOTH, is_lw, S_EX1, 1, 0);
    if (kind == K_ADD) begin
      drv(run_end, 1, 0, 0, endst, 1, 1);
      return;
    end
    drv(1, 1, 0, 0, S_EX2, 1, 0);
    if (exw == 0) begin
      for (int i = 1; i <= TMO; i++) begin
        if (i == TMO) exp_err = 1'b1;
        drv(1, 0, 0, 0, (i == TMO) ? S_IDLE : S_EX2, 0, 0);
      end
      return;
    end
    for (int i = 1; i <= exw; i++) begin
      if (i < exw)    drv(run_end, 0, 0, 0, S_EX2, 0, 0);
      else if (is_lw) drv(run_end, 1, 0, 0, S_EX3, 1, 0);
      else            drv(run_end, 1, 0, 0, endst, 1, 1);
    end
    if (is_lw) drv(run_end, 1, 0, 0, endst, 1, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    do_rst();
    do_rst();
    drv(0, 0, 0, 0, S_IDLE, 0, 0);
    drv(0, 1, 0, 0, S_IDLE, 0, 0);
    // ADD, IF1 done on its third cycle, stays running
    start();
    run_instr(K_ADD, 3, 0, 1);
    // LW with a 5-cycle EX2 dwell, then LW+SW flags together
    run_instr(K_LW, 2, 5, 1);
    run_instr(K_BOTH, 1, 1, 1);
    // SW with run dropped during EX2: completes and parks in IDLE
    run_instr(K_SW, 1, 3, 0);
    drv(0, 0, 0, 0, S_IDLE, 0, 0);
    start();
    // output_done on the expiry cycle of IF1
    run_instr(K_ADD, TMO, 0, 1);
    // EX2 of SW hangs -> timeout, then run is ignored
    run_instr(K_SW, 1, 0, 1);
    repeat (3) drv(1, 0, 0, 0, S_IDLE, 0, 0);
    do_rst();
    // IF1 hangs for TIMEOUT cycles
    start();
    for (int i = 1; i <= TMO; i++) begin
      if (i == TMO) exp_err = 1'b1;
      drv(1, 0, 0, 0, (i == TMO) ? S_IDLE : S_IF1, 0, 0);
    end
    repeat (3) drv(1, 1, 0, 0, S_IDLE, 0, 0);
    do_rst();
    // Reset in the middle of an LW's EX2
    start();
    run_instr(K_ADD, 1, 0, 1);
    drv(1, 1, 0, 0, S_IF2, 1, 0);
    drv(1, 1, 0, 1, S_EX1, 1, 0);
    drv(1, 1, 0, 0, S_EX2, 1, 0);
    drv(1, 0, 0, 0, S_EX2, 0, 0);
    do_rst();
    drv(0, 0, 0, 0, S_IDLE, 0, 0);
    // 16 back-to-back ADDs wrap the 4-bit counter to 0
    start();
    for (int k = 0; k < 16; k++) run_instr(K_ADD, 1, 0, k != 15);
    drv(0, 0, 0, 0, S_IDLE, 0, 0);
    repeat (3) @(posedge clk);
    #5;
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
